// File: rtl/imem_boot_responder.sv
// Instruction-side responder: byte-stream boot loader, instruction memory and
// core reset sequencer. Bytes arrive big-endian, are packed into 32-bit words
// and written to memory; the core is held in reset until the load completes
// plus HOLD_CYC cycles, after which fetches are served combinationally.
// Optional feature (macro IMEM_RELOAD_EN): a byte offered in RUN restarts
// loading without an external reset.
module imem_boot_responder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned HOLD_CYC   = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [7:0]            ld_byte,
  input  logic                  ld_last,
  input  logic [31:0]           PC,
  output logic [31:0]           Instr,
  output logic                  cpu_rstn,
  output logic                  load_done,
  output logic [DEPTH_LOG2:0]   word_count,
  output logic                  err_overflow
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FullCount = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CntOne    = 1;
  localparam logic [DEPTH_LOG2-1:0] PtrOne    = 1;
  localparam logic [7:0]            HoldLast  = 8'(HOLD_CYC - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StHold, StRun} state_e;

  state_e                state_q, state_d;
  logic [1:0]            lane_q, lane_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   word_count_q, word_count_d;
  logic [31:0]           asm_q, asm_d;
  logic [7:0]            hold_cnt_q, hold_cnt_d;
  logic                  err_q, err_d;
  logic                  cpu_rstn_q, cpu_rstn_d;

  logic [31:0] mem_q [Depth];

  logic                  ready_int;
  logic                  accept;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [31:0]           mem_wdata;
  logic [DEPTH_LOG2:0]   base_wc;
  logic [DEPTH_LOG2-1:0] base_wr;
  logic [1:0]            base_lane;
  logic                  base_err;
  logic [31:0]           placed;

  // Ready is forced low while reset is asserted, independent of state.
  assign ld_ready = ready_int & ~RST;
  assign accept   = ld_valid & ld_ready;

  // Next-state: byte packing, memory write strobe, hold countdown.
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    wr_ptr_d     = wr_ptr_q;
    word_count_d = word_count_q;
    asm_d        = asm_q;
    hold_cnt_d   = hold_cnt_q;
    err_d        = err_q;
    ready_int    = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = wr_ptr_q;
    mem_wdata    = 32'h0;
    base_wc      = word_count_q;
    base_wr      = wr_ptr_q;
    base_lane    = lane_q;
    base_err     = err_q;
    placed       = 32'h0;

    unique case (state_q)
      StIdle, StLoad: ready_int = 1'b1;
`ifdef IMEM_RELOAD_EN
      StRun:          ready_int = 1'b1;
`else
      StRun:          ready_int = 1'b0;
`endif
      default:        ready_int = 1'b0;
    endcase

    if (accept) begin
`ifdef IMEM_RELOAD_EN
      // A byte in RUN starts a fresh image from word 0.
      if (state_q == StRun) begin
        base_wc   = '0;
        base_wr   = '0;
        base_lane = 2'd0;
        base_err  = 1'b0;
      end
`endif
      // Lane 0 starts a new word, so lower bytes are zero until filled.
      unique case (base_lane)
        2'd0:    placed = {ld_byte, 24'h0};
        2'd1:    placed = {asm_q[31:24], ld_byte, 16'h0};
        2'd2:    placed = {asm_q[31:16], ld_byte, 8'h0};
        default: placed = {asm_q[31:8], ld_byte};
      endcase

      state_d      = StLoad;
      word_count_d = base_wc;
      wr_ptr_d     = base_wr;
      lane_d       = base_lane;
      err_d        = base_err;

      if (base_wc == FullCount) begin
        // Memory full: byte is consumed but dropped.
        err_d = 1'b1;
      end else begin
        asm_d = placed;
        if (base_lane == 2'd3 || ld_last) begin
          mem_we       = 1'b1;
          mem_waddr    = base_wr;
          mem_wdata    = placed;
          wr_ptr_d     = base_wr + PtrOne;
          word_count_d = base_wc + CntOne;
          lane_d       = 2'd0;
        end else begin
          lane_d = base_lane + 2'd1;
        end
      end

      if (ld_last) begin
        state_d    = StHold;
        lane_d     = 2'd0;
        hold_cnt_d = 8'h0;
      end
    end else if (state_q == StHold) begin
      if (hold_cnt_q == HoldLast) begin
        state_d = StRun;
      end else begin
        hold_cnt_d = hold_cnt_q + 8'd1;
      end
    end

    // Registered so the core reset releases exactly on the edge entering RUN.
    cpu_rstn_d = (state_d == StRun);
  end

  // Control state with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      lane_q       <= 2'd0;
      wr_ptr_q     <= '0;
      word_count_q <= '0;
      asm_q        <= 32'h0;
      hold_cnt_q   <= 8'h0;
      err_q        <= 1'b0;
      cpu_rstn_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      wr_ptr_q     <= wr_ptr_d;
      word_count_q <= word_count_d;
      asm_q        <= asm_d;
      hold_cnt_q   <= hold_cnt_d;
      err_q        <= err_d;
      cpu_rstn_q   <= cpu_rstn_d;
    end
  end

  // Instruction memory; contents survive reset, visibility is gated by word_count.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  logic [29:0]           wc_ext;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  fetch_ok;

  // Full-width compare so addresses above the array never alias low words.
  assign wc_ext   = 30'(word_count_q);
  assign rd_idx   = PC[DEPTH_LOG2+1:2];
  assign fetch_ok = (state_q == StRun) && (PC[1:0] == 2'b00) && (PC[31:2] < wc_ext);

  // Combinational fetch; anything not servable returns a NOP.
  always_comb begin
    Instr = 32'h0;
    if (fetch_ok) begin
      Instr = mem_q[rd_idx];
    end
  end

  assign cpu_rstn     = cpu_rstn_q;
  assign load_done    = (state_q == StRun);
  assign word_count   = word_count_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_imem_boot_responder.sv
// Directed bench for imem_boot_responder. Two instances share one byte
// stream: a default-depth one and a 4-word one that exercises overflow.
module tb_imem_boot_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic [31:0] PC;

  logic        rdy1, rstn1, done1, err1;
  logic [31:0] instr1;
  logic [8:0]  wc1;
  logic        rdy2, rstn2, done2, err2;
  logic [31:0] instr2;
  logic [2:0]  wc2;

  int total = 0;
  int bad   = 0;

  logic [7:0] prog [0:31];

  always #5 CLK = ~CLK;

  imem_boot_responder #(.DEPTH_LOG2(8), .HOLD_CYC(4)) dut1 (
    .CLK(CLK), .RST(RST), .ld_valid(ld_valid), .ld_ready(rdy1), .ld_byte(ld_byte),
    .ld_last(ld_last), .PC(PC), .Instr(instr1), .cpu_rstn(rstn1), .load_done(done1),
    .word_count(wc1), .err_overflow(err1)
  );

  imem_boot_responder #(.DEPTH_LOG2(2), .HOLD_CYC(4)) dut2 (
    .CLK(CLK), .RST(RST), .ld_valid(ld_valid), .ld_ready(rdy2), .ld_byte(ld_byte),
    .ld_last(ld_last), .PC(PC), .Instr(instr2), .cpu_rstn(rstn2), .load_done(done2),
    .word_count(wc2), .err_overflow(err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Offer one byte from a falling edge; returns 1 time unit after the accepting edge.
  task automatic send(input logic [7:0] b, input logic last);
    int n;
    @(negedge CLK);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    n = 0;
    while (!rdy1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n == 50) check("ready_timeout", {31'h0, rdy1}, 32'h1);
    @(posedge CLK);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic load_prog(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      send(prog[i], i == n - 1);
      if (gap) @(negedge CLK);
    end
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (!done1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("run_reached", {31'h0, done1}, 32'h1);
  endtask

  task automatic pulse_rst();
    @(negedge CLK);
    RST = 1'b1;
    #3;
    RST = 1'b0;
  endtask

  task automatic fetch1(input string tag, input logic [31:0] pc, input logic [31:0] exp);
    PC = pc;
    #1;
    check(tag, instr1, exp);
  endtask

  task automatic fetch2(input string tag, input logic [31:0] pc, input logic [31:0] exp);
    PC = pc;
    #1;
    check(tag, instr2, exp);
  endtask

  task automatic set_prog_t1();
    prog[0] = 8'h20; prog[1] = 8'h08; prog[2] = 8'h00; prog[3] = 8'h05;
    prog[4] = 8'h20; prog[5] = 8'h09; prog[6] = 8'h00; prog[7] = 8'h07;
  endtask

  initial begin
    RST      = 1'b1;
    ld_valid = 1'b0;
    ld_byte  = 8'h0;
    ld_last  = 1'b0;
    PC       = 32'h0;

    // Reset state
    #2;
    check("rst_ready", {31'h0, rdy1}, 32'h0);
    check("rst_rstn", {31'h0, rstn1}, 32'h0);
    check("rst_done", {31'h0, done1}, 32'h0);
    check("rst_wc", {23'h0, wc1}, 32'h0);
    check("rst_err", {31'h0, err1}, 32'h0);
    check("rst_instr", instr1, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("idle_ready", {31'h0, rdy1}, 32'h1);

    // Two full words, back-to-back, with hold timing
    set_prog_t1();
    load_prog(8, 1'b0);
    PC = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("hold_rstn_low", {31'h0, rstn1}, 32'h0);
      check("hold_ready", {31'h0, rdy1}, 32'h0);
      check("hold_instr", instr1, 32'h0);
    end
    @(negedge CLK);
    check("run_rstn", {31'h0, rstn1}, 32'h1);
    check("run_done", {31'h0, done1}, 32'h1);
    check("t1_wc", {23'h0, wc1}, 32'd2);
    fetch1("t1_pc0", 32'h0, 32'h20080005);
    fetch1("t1_pc4", 32'h4, 32'h20090007);
    fetch1("t1_pc8", 32'h8, 32'h0);
`ifdef IMEM_RELOAD_EN
    check("run_ready_reload", {31'h0, rdy1}, 32'h1);
`else
    check("run_ready", {31'h0, rdy1}, 32'h0);
`endif

    // Partial final word
    pulse_rst();
    prog[0] = 8'hAA; prog[1] = 8'hBB; prog[2] = 8'hCC; prog[3] = 8'hDD;
    prog[4] = 8'h11; prog[5] = 8'h22;
    load_prog(6, 1'b0);
    wait_run();
    check("t2_wc", {23'h0, wc1}, 32'd2);
    fetch1("t2_pc0", 32'h0, 32'hAABBCCDD);
    fetch1("t2_pc4", 32'h4, 32'h11220000);
    fetch1("t2_misalign", 32'h2, 32'h0);
    fetch1("t2_high_pc", 32'h1000_0000, 32'h0);

    // Gapped valid gives the same image
    pulse_rst();
    set_prog_t1();
    load_prog(8, 1'b1);
    wait_run();
    check("t3_wc", {23'h0, wc1}, 32'd2);
    fetch1("t3_pc0", 32'h0, 32'h20080005);
    fetch1("t3_pc4", 32'h4, 32'h20090007);
`ifndef IMEM_RELOAD_EN
    check("t3_ready_run", {31'h0, rdy1}, 32'h0);
`endif

    // Overflow on the 4-word instance
    pulse_rst();
    for (int i = 0; i < 20; i++) prog[i] = 8'(i + 1);
    load_prog(20, 1'b0);
    wait_run();
    check("t4_wc_big", {23'h0, wc1}, 32'd5);
    check("t4_err_big", {31'h0, err1}, 32'h0);
    check("t4_wc_small", {29'h0, wc2}, 32'd4);
    check("t4_err_small", {31'h0, err2}, 32'h1);
    check("t4_done_small", {31'h0, done2}, 32'h1);
    fetch2("t4_s_pc0", 32'h0, 32'h01020304);
    fetch2("t4_s_pc4", 32'h4, 32'h05060708);
    fetch2("t4_s_pc8", 32'h8, 32'h090A0B0C);
    fetch2("t4_s_pc12", 32'hC, 32'h0D0E0F10);
    fetch2("t4_s_pc16", 32'h10, 32'h0);
    fetch1("t4_b_pc16", 32'h10, 32'h11121314);

    // Reset mid-load, then a fresh single word
    pulse_rst();
    set_prog_t1();
    for (int i = 0; i < 5; i++) send(prog[i], 1'b0);
    check("t5_mid_wc", {23'h0, wc1}, 32'd1);
    pulse_rst();
    #1;
    check("t5_rst_wc", {23'h0, wc1}, 32'd0);
    prog[0] = 8'h3C; prog[1] = 8'h01; prog[2] = 8'hFF; prog[3] = 8'hFF;
    load_prog(4, 1'b0);
    wait_run();
    check("t5_wc", {23'h0, wc1}, 32'd1);
    fetch1("t5_pc0", 32'h0, 32'h3C01FFFF);
    fetch1("t5_pc4", 32'h4, 32'h0);

`ifdef IMEM_RELOAD_EN
    // Reload from RUN without RST
    PC = 32'h0;
    send(8'h00, 1'b0);
    check("rl_rstn", {31'h0, rstn1}, 32'h0);
    check("rl_done", {31'h0, done1}, 32'h0);
    check("rl_wc0", {23'h0, wc1}, 32'd0);
    check("rl_instr0", instr1, 32'h0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h20, 1'b1);
    wait_run();
    check("rl_wc", {23'h0, wc1}, 32'd1);
    fetch1("rl_pc0", 32'h0, 32'h00000020);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_responder.md
Name: imem_boot_responder

Overview:
- Instruction-side responder for the pipelined MIPS core. The core presents PC and expects Instr in the same cycle.
- Contains the instruction memory and a byte-stream loader that fills it after reset.
- Holds the core in reset until a program is loaded, then serves instruction fetches combinationally.
- Sits between the testbench/boot host and the core's CLK/RSTn/Instr/PC pins.

Parameters:
- DEPTH_LOG2, 8, log2 of memory depth in 32-bit words (default 256 words).
- HOLD_CYC, 4, cycles cpu_rstn is kept low after load completes (range 1..255).

Ports:
- CLK  input  1  system clock, all state on rising edge.
- RST  input  1  asynchronous, active-high reset.
- ld_valid  input  1  host offers a program byte.
- ld_ready  output  1  block accepts a byte this cycle.
- ld_byte  input  8  program byte, big-endian within word.
- ld_last  input  1  qualifies the final byte of the program.
- PC  input  32  fetch address from core.
- Instr  output  32  instruction for PC (combinational).
- cpu_rstn  output  1  active-low reset to core (drives core RSTn).
- load_done  output  1  high while in RUN.
- word_count  output  DEPTH_LOG2+1  number of words written.
- err_overflow  output  1  sticky, set when a byte arrives with memory full.

Behaviour:
- Interface is fixed: one clock CLK; reset RST is asynchronous and active-high.
- On RST:
  - State = IDLE; lane = 0; wr_ptr = 0; word_count = 0; assembly register = 0; hold counter = 0.
  - err_overflow = 0, cpu_rstn = 0, load_done = 0.
  - ld_ready = 0 while RST is high.
  - Memory array is not cleared.
- Byte transfer: a byte is accepted on a rising edge with ld_valid && ld_ready. ld_byte and ld_last are sampled only then.
- FSM states: IDLE, LOAD, HOLD, RUN.
- IDLE:
  - ld_ready = 1.
  - First accepted byte goes to LOAD, processed as in LOAD.
  - If that byte has ld_last = 1, go straight to HOLD.
- LOAD:
  - ld_ready = 1.
  - Byte lane 0 goes to bits 31:24, lane 1 to 23:16, lane 2 to 15:8, lane 3 to 7:0.
  - On lane 3 accept: write the assembled word to mem[wr_ptr], wr_ptr++, word_count++, lane = 0.
- ld_last handling:
  - If lane != 3 and lane != 0, the partial word is written with the unfilled low bytes = 0, and word_count++.
  - If the last byte lands in lane 0 it is a new word and is written padded, the same as a partial word.
  - After ld_last, go to HOLD and clear lane.
- Overflow:
  - When word_count == 2^DEPTH_LOG2, bytes are still accepted but discarded. err_overflow is set. No write occurs and word_count saturates.
  - ld_last still terminates the load.
- HOLD:
  - ld_ready = 0, cpu_rstn = 0.
  - Counter runs 0..HOLD_CYC-1, then go to RUN.
- RUN:
  - cpu_rstn = 1, load_done = 1, ld_ready = 0.
  - cpu_rstn is registered and rises on the same edge that enters RUN.
- Fetch (combinational):
  - Instr = mem[PC[DEPTH_LOG2+1:2]] only when state == RUN, PC[1:0] == 0, and PC[31:2] < word_count. The compare uses full PC[31:2] width, so high addresses are out of range.
  - Otherwise Instr = 0 (sll $0 NOP).
- Memory writes occur only in IDLE/LOAD and reads are served only in RUN, so there is no read/write collision (except under the optional feature).
- RST asserted mid-load or mid-run returns to IDLE immediately. Previously written words become invisible because word_count = 0.

Optional Feature:
- Macro: IMEM_RELOAD_EN.
- Defined:
  - In RUN, ld_ready = 1.
  - An accepted byte drops cpu_rstn and load_done on the same edge, clears word_count, wr_ptr and err_overflow, and enters LOAD with that byte as lane 0.
  - Instr returns 0 from that edge on.
  - The reload then proceeds as a normal load.
- Undefined:
  - ld_ready stays 0 in RUN. Only RST restarts loading.

Test Plan:
- Load 8 bytes 20,08,00,05,20,09,00,07 (ld_last on byte 8) → word_count = 2. cpu_rstn low for 4 cycles after the last accept, then high. PC=0 gives Instr=0x20080005; PC=4 gives 0x20090007; PC=8 gives 0.
- Load 6 bytes AA,BB,CC,DD,11,22 with last on byte 6 → word 1 = 0x11220000, word_count = 2. Misaligned PC=2 gives Instr=0.
- ld_valid toggled every other cycle during the load → the same memory image as a back-to-back load. ld_ready is never high in HOLD/RUN (macro off).
- DEPTH_LOG2=2: load 20 bytes → word_count = 4, err_overflow = 1, mem[0..3] intact, FSM reaches RUN.
- RST pulsed after 5 of 8 bytes, then a fresh 4-byte load of 0x3C01FFFF → word_count = 1, PC=0 gives 0x3C01FFFF, PC=4 gives 0.
- With IMEM_RELOAD_EN: in RUN, send 4 bytes 00,00,00,20 with last → cpu_rstn falls on the first accept, word_count = 1, Instr at PC=0 = 0x00000020 after the HOLD period.
